mac_tx_arbiter: RTL and testbench
=================================

Name: mac_tx_arbiter

Overview:
- Frame-granular round-robin arbiter that shares the single MAC TX AXI-Stream input among N_SRC independent AXI-Stream frame sources.
- Sits directly in front of the MAC TX controller.
- Guarantees each frame reaches the MAC as an unbroken beat sequence; the MAC treats a mid-frame valid gap as fatal.
- If a granted source underruns mid-frame, the arbiter closes the frame (tlast, tkeep=0), flags it, and drains the rest of that source's frame.

Parameters:
N_SRC, 4, number of requesting sources (2..8)
N_SYMBOLS, 4, bytes per beat (from cmn_params)
W_SYMBOL, 8, bits per byte lane

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_clk_en  in  1  datapath clock enable; no state advances and no transfer completes when low
i_src_en  in  N_SRC  per-source enable mask; only gates new grants
s_axis_tvalid  in  N_SRC  per-source valid
s_axis_tkeep  in  N_SRC x N_SYMBOLS  per-source byte keep
s_axis_tdata  in  N_SRC x N_SYMBOLS x W_SYMBOL  per-source data
s_axis_tlast  in  N_SRC  per-source last
s_axis_tready  out  N_SRC  per-source ready
m_axis_tvalid  out  1  to MAC TX
m_axis_tkeep  out  N_SYMBOLS  to MAC TX
m_axis_tdata  out  N_SYMBOLS x W_SYMBOL  to MAC TX
m_axis_tlast  out  1  to MAC TX
m_axis_tready  in  1  from MAC TX; already includes clk_en gating
o_grant  out  N_SRC  registered one-hot current owner; 0 when idle
o_underrun  out  N_SRC  one-cycle pulse: frame of that source was aborted
o_frame_done  out  1  one-cycle pulse on the accepted tlast beat of a normal frame

Behaviour:
- Handshake definitions:
  - xfer_m = m_axis_tvalid & m_axis_tready & i_clk_en.
  - xfer_s[i] = s_axis_tvalid[i] & s_axis_tready[i].
- Reset: state ST_IDLE; o_grant=0; rr pointer q_last=N_SRC-1, so source 0 wins first; q_started=0; all outputs 0.
- All registers update only when i_clk_en=1. Reset overrides i_clk_en.
- ST_IDLE:
  - m_axis_tvalid=0; all s_axis_tready=0.
  - Request set = s_axis_tvalid & i_src_en.
  - Winner = first set bit scanning q_last+1, q_last+2, ... modulo N_SRC.
  - On a winner: register o_grant=onehot(winner) and go to ST_GRANT.
  - Arbitration latency is 1 cycle; the first beat can transfer on the cycle after the grant.
- ST_GRANT (g = granted index):
  - m_axis_* mirror source g combinationally.
  - s_axis_tready[g] = m_axis_tready & i_clk_en; all other readies are 0.
  - xfer_m with tlast=0: set q_started.
  - xfer_m with tlast=1: pulse o_frame_done, set q_last=g, clear o_grant and q_started, go to ST_IDLE.
  - Underrun: q_started & m_axis_tready & i_clk_en & !s_axis_tvalid[g] → go to ST_ABORT. The source is not ready that cycle.
  - Retraction before the first beat (!q_started & !s_axis_tvalid[g]): return to ST_IDLE with no flag; q_last is unchanged.
- ST_ABORT:
  - Drive m_axis_tvalid=1, tlast=1, tkeep=0, tdata=0; all s_axis_tready=0.
  - On xfer_m: pulse o_underrun[g] and go to ST_DROP.
- ST_DROP:
  - m_axis_tvalid=0; s_axis_tready[g]=i_clk_en.
  - Beats from g are discarded.
  - On xfer_s[g] with tlast: set q_last=g, clear o_grant, go to ST_IDLE.
- i_src_en deassertion while a source is granted does not affect its in-flight frame.
- While m_axis_tready is low (MAC in CRC/term/IFG), the arbiter holds its state. Invalid source beats in that window are not an underrun.
- Width rule: rr scan index is $clog2(N_SRC) bits, wrapping modulo N_SRC.
- Reset mid-frame returns to ST_IDLE immediately; the source's partial frame is the source's responsibility.
- Outputs in ST_IDLE/ST_DROP: m_axis_tkeep, tdata and tlast are 0.

Test Plan:
- All 4 sources hold a 3-beat frame from reset → grant order 0,1,2,3,0; o_frame_done pulses 4 times per round; no beat interleaving on m_axis.
- Only src 2 requests with i_src_en=4'b1011 → no grant. Set bit 2 → o_grant=4'b0100 one cycle later.
- src 1 sends beat 1, drops tvalid for 1 cycle while m_axis_tready=1 → m_axis beat 2 is {tlast=1, tkeep=0}; o_underrun=4'b0010; remaining src 1 beats are consumed through its tlast with m_axis_tvalid=0; next grant goes to src 2.
- i_clk_en toggling 1,0,1,0 during a 5-beat frame → exactly 5 m_axis transfers, each only on clk_en=1 cycles; data unchanged.
- m_axis_tready held low 6 cycles after tlast while src 0 and src 3 request → no transfers. When ready rises: grant src 0 if the previous owner was src 3, or src 3 if the previous owner was src 2.
- Assert i_reset during beat 2 of a src 0 frame → next cycle o_grant=0 and all readies 0. After release, src 0 wins first arbitration.

Source files
------------

// File: rtl/mac_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the single MAC TX AXI-Stream input.
// Frames leave unbroken; a mid-frame source underrun is closed with an empty tlast beat.
module mac_tx_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned N_SYMBOLS = 4,
    parameter int unsigned W_SYMBOL  = 8
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_clk_en,
    input  logic [N_SRC-1:0]                    i_src_en,
    input  logic [N_SRC-1:0]                    s_axis_tvalid,
    input  logic [N_SRC*N_SYMBOLS-1:0]          s_axis_tkeep,
    input  logic [N_SRC*N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0]                    s_axis_tlast,
    output logic [N_SRC-1:0]                    s_axis_tready,
    output logic                                m_axis_tvalid,
    output logic [N_SYMBOLS-1:0]                m_axis_tkeep,
    output logic [N_SYMBOLS*W_SYMBOL-1:0]       m_axis_tdata,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,
    output logic [N_SRC-1:0]                    o_grant,
    output logic [N_SRC-1:0]                    o_underrun,
    output logic                                o_frame_done
);

    localparam int unsigned IDX_W  = $clog2(N_SRC);
    localparam int unsigned DATA_W = N_SYMBOLS * W_SYMBOL;

    typedef enum logic [1:0] {StIdle, StGrant, StAbort, StDrop} state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             started_q, started_d;

    logic [N_SRC-1:0]     req;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic                 g_valid;
    logic                 g_last;
    logic [N_SYMBOLS-1:0] g_keep;
    logic [DATA_W-1:0]    g_data;
    logic                 g_xfer_m;
    logic                 underrun;

    assign req = s_axis_tvalid & i_src_en;

    // Scan starts one past the previous owner and wraps modulo N_SRC.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand = IDX_W'((32'(last_q) + k) % N_SRC);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign g_valid = s_axis_tvalid[gidx_q];
    assign g_last  = s_axis_tlast[gidx_q];
    assign g_keep  = s_axis_tkeep[32'(gidx_q) * N_SYMBOLS +: N_SYMBOLS];
    assign g_data  = s_axis_tdata[32'(gidx_q) * DATA_W +: DATA_W];

    assign g_xfer_m = g_valid & m_axis_tready & i_clk_en;
    // Only a gap after the first beat is fatal; a stalled MAC masks invalid beats.
    assign underrun = started_q & m_axis_tready & i_clk_en & ~g_valid;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        last_d        = last_q;
        started_d     = started_q;
        m_axis_tvalid = 1'b0;
        m_axis_tkeep  = '0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        o_underrun    = '0;
        o_frame_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d          = StGrant;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    gidx_d           = win_idx;
                end
            end

            StGrant: begin
                m_axis_tvalid = g_valid;
                m_axis_tkeep  = g_keep;
                m_axis_tdata  = g_data;
                m_axis_tlast  = g_last;
                if (underrun) begin
                    state_d = StAbort;
                end else begin
                    s_axis_tready = grant_q & {N_SRC{m_axis_tready & i_clk_en}};
                    if (g_xfer_m) begin
                        if (g_last) begin
                            o_frame_done = 1'b1;
                            last_d       = gidx_q;
                            grant_d      = '0;
                            started_d    = 1'b0;
                            state_d      = StIdle;
                        end else begin
                            started_d = 1'b1;
                        end
                    end else if (!started_q && !g_valid) begin
                        // Source withdrew before its first beat: release without touching rr.
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end
            end

            StAbort: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                if (m_axis_tready && i_clk_en) begin
                    o_underrun = grant_q;
                    started_d  = 1'b0;
                    state_d    = StDrop;
                end
            end

            StDrop: begin
                s_axis_tready = grant_q & {N_SRC{i_clk_en}};
                if (g_valid && i_clk_en && g_last) begin
                    last_d  = gidx_q;
                    grant_d = '0;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d   = StIdle;
                grant_d   = '0;
                started_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IDX_W'(N_SRC - 1);
            started_q <= 1'b0;
        end else if (i_clk_en) begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            started_q <= started_d;
        end
    end

    assign o_grant = grant_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: four scripted frame sources and an m_axis recorder.
module tb_mac_tx_arbiter;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_clk_en;
    logic [3:0]   i_src_en;
    logic [3:0]   s_axis_tvalid;
    logic [15:0]  s_axis_tkeep;
    logic [127:0] s_axis_tdata;
    logic [3:0]   s_axis_tlast;
    logic [3:0]   s_axis_tready;
    logic         m_axis_tvalid;
    logic [3:0]   m_axis_tkeep;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic [3:0]   o_grant;
    logic [3:0]   o_underrun;
    logic         o_frame_done;

    mac_tx_arbiter #(
        .N_SRC    (4),
        .N_SYMBOLS(4),
        .W_SYMBOL (8)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clk_en     (i_clk_en),
        .i_src_en     (i_src_en),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .o_grant      (o_grant),
        .o_underrun   (o_underrun),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int und_cnt  = 0;
    int bad      = 0;
    int base     = 0;
    logic [3:0] und_seen   = '0;
    logic [3:0] prev_grant = '0;
    logic [3:0] xs         = '0;
    logic [36:0] beat_q[$];
    logic [3:0]  gnt_q[$];

    // Source script state: frames left, beats per frame, beat position, frame counter.
    int frames[4];
    int len[4];
    int pos[4];
    int fcnt[4];
    bit gap[4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [36:0] exp_beat(input int s, input int f, input int b, input bit last);
        logic [7:0] sb, fb, bb;
        sb = 8'(s);
        fb = 8'(f);
        bb = 8'(b);
        return {last, 4'hF, sb, fb, bb, 8'hA5};
    endfunction

    function automatic logic [36:0] get_beat(input int k);
        if (k < beat_q.size()) return beat_q[k];
        return '1;
    endfunction

    function automatic logic [3:0] get_gnt(input int k);
        if (k < gnt_q.size()) return gnt_q[k];
        return 4'hF;
    endfunction

    task automatic drive();
        for (int s = 0; s < 4; s++) begin
            bit v;
            v = (frames[s] > 0) && !gap[s];
            s_axis_tvalid[s]        = v;
            s_axis_tlast[s]         = v && (pos[s] == len[s] - 1);
            s_axis_tkeep[s*4 +: 4]  = v ? 4'hF : 4'h0;
            s_axis_tdata[s*32 +: 32] = {8'(s), 8'(fcnt[s]), 8'(pos[s]), 8'hA5};
        end
        #1;
    endtask

    // Observe on the falling edge, then advance the sources after the rising edge.
    task automatic tick();
        @(negedge i_clk);
        xs = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready && i_clk_en)
            beat_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        if (o_frame_done) done_cnt++;
        if (|o_underrun) begin
            und_cnt++;
            und_seen = und_seen | o_underrun;
        end
        if (o_grant != prev_grant && o_grant != 4'b0) gnt_q.push_back(o_grant);
        prev_grant = o_grant;
        if (!i_clk_en && ((|s_axis_tready) || o_frame_done || (|o_underrun))) bad++;
        @(posedge i_clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            if (xs[s]) begin
                if (pos[s] == len[s] - 1) begin
                    pos[s] = 0;
                    fcnt[s]++;
                    frames[s]--;
                end else begin
                    pos[s]++;
                end
            end
        end
        drive();
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt < target; i++) tick();
        check(tag, 64'(done_cnt), 64'(target));
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            frames[s] = 0;
            len[s]    = 1;
            pos[s]    = 0;
            fcnt[s]   = 0;
            gap[s]    = 1'b0;
        end
        i_reset       = 1'b1;
        i_clk_en      = 1'b1;
        i_src_en      = 4'hF;
        m_axis_tready = 1'b1;
        drive();
        tick();
        tick();
        check("rst_grant", o_grant, 4'b0);
        check("rst_ready", s_axis_tready, 4'b0);
        check("rst_mvalid", m_axis_tvalid, 1'b0);
        check("rst_mdata", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 37'h0);
        check("rst_pulses", {o_frame_done, o_underrun}, 5'h0);
        i_reset = 1'b0;
        drive();

        // All four sources with two 3-beat frames each.
        beat_q.delete();
        gnt_q.delete();
        for (int s = 0; s < 4; s++) begin
            len[s]    = 3;
            frames[s] = 2;
        end
        drive();
        wait_done(8, 100, "t1_done");
        for (int j = 0; j < 8; j++) check("t1_grant_order", get_gnt(j), 4'b0001 << (j % 4));
        check("t1_beats", beat_q.size(), 24);
        for (int j = 0; j < 8; j++)
            for (int b = 0; b < 3; b++)
                check("t1_beat", get_beat(j * 3 + b), exp_beat(j % 4, j / 4, b, b == 2));

        // Masked requester gets no grant until enabled.
        beat_q.delete();
        base     = done_cnt;
        i_src_en = 4'b1011;
        len[2]   = 3;
        frames[2] = 1;
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_masked_grant", o_grant, 4'b0);
        end
        check("t2_masked_mvalid", m_axis_tvalid, 1'b0);
        i_src_en = 4'hF;
        drive();
        tick();
        check("t2_grant", o_grant, 4'b0100);
        wait_done(base + 1, 20, "t2_done");
        for (int b = 0; b < 3; b++) check("t2_beat", get_beat(b), exp_beat(2, 2, b, b == 2));

        // Source 1 underruns after its first beat.
        beat_q.delete();
        base      = done_cnt;
        len[1]    = 4;
        frames[1] = 1;
        drive();
        tick();
        check("t3_grant", o_grant, 4'b0010);
        check("t3_first_data", m_axis_tdata, 37'(exp_beat(1, 2, 0, 1'b0)) & 37'hFFFFFFFF);
        tick();
        gap[1] = 1'b1;
        drive();
        check("t3_gap_ready", s_axis_tready, 4'b0);
        check("t3_gap_mvalid", m_axis_tvalid, 1'b0);
        check("t3_gap_underrun", o_underrun, 4'b0);
        tick();
        gap[1]    = 1'b0;
        len[0]    = 2;
        frames[0] = 1;
        len[2]    = 2;
        frames[2] = 1;
        drive();
        check("t3_abort_beat", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
              38'h30_0000_0000);
        check("t3_abort_ready", s_axis_tready, 4'b0);
        check("t3_abort_flag", o_underrun, 4'b0010);
        check("t3_abort_done", o_frame_done, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t3_drop_mvalid", m_axis_tvalid, 1'b0);
            check("t3_drop_ready", s_axis_tready, 4'b0010);
            tick();
        end
        check("t3_drained", frames[1], 0);
        check("t3_idle_grant", o_grant, 4'b0);
        tick();
        check("t3_next_grant", o_grant, 4'b0100);
        wait_done(base + 2, 30, "t3_done");
        check("t3_underrun_cnt", und_cnt, 1);
        check("t3_underrun_src", und_seen, 4'b0010);
        check("t3_beats", beat_q.size(), 6);
        check("t3_b0", get_beat(0), exp_beat(1, 2, 0, 1'b0));
        check("t3_b1", get_beat(1), {1'b1, 36'h0});
        check("t3_b2", get_beat(2), exp_beat(2, 3, 0, 1'b0));
        check("t3_b3", get_beat(3), exp_beat(2, 3, 1, 1'b1));
        check("t3_b4", get_beat(4), exp_beat(0, 2, 0, 1'b0));
        check("t3_b5", get_beat(5), exp_beat(0, 2, 1, 1'b1));

        // 5-beat frame from source 3 with the clock enable toggling.
        beat_q.delete();
        base      = done_cnt;
        bad       = 0;
        len[3]    = 5;
        frames[3] = 1;
        for (int i = 0; i < 40 && done_cnt < base + 1; i++) begin
            i_clk_en = (i % 2 == 0);
            drive();
            tick();
        end
        i_clk_en = 1'b1;
        drive();
        check("t4_done", done_cnt, base + 1);
        check("t4_beats", beat_q.size(), 5);
        for (int b = 0; b < 5; b++) check("t4_beat", get_beat(b), exp_beat(3, 2, b, b == 4));
        check("t4_gated", bad, 0);

        // MAC stalls for 6 cycles while sources 0 and 3 request.
        beat_q.delete();
        base          = done_cnt;
        m_axis_tready = 1'b0;
        len[0]        = 2;
        frames[0]     = 1;
        len[3]        = 2;
        frames[3]     = 1;
        drive();
        tick();
        check("t5_grant", o_grant, 4'b0001);
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_xfer", beat_q.size(), 0);
        check("t5_hold_grant", o_grant, 4'b0001);
        check("t5_hold_mvalid", m_axis_tvalid, 1'b1);
        check("t5_hold_ready", s_axis_tready, 4'b0);
        check("t5_hold_underrun", und_cnt, 1);
        m_axis_tready = 1'b1;
        drive();
        wait_done(base + 2, 30, "t5_done");
        check("t5_b0", get_beat(0), exp_beat(0, 3, 0, 1'b0));
        check("t5_b1", get_beat(1), exp_beat(0, 3, 1, 1'b1));
        check("t5_b2", get_beat(2), exp_beat(3, 3, 0, 1'b0));
        check("t5_b3", get_beat(3), exp_beat(3, 3, 1, 1'b1));

        // Reset mid-frame, with clock enable low, restores the rr pointer.
        base      = done_cnt;
        len[1]    = 2;
        frames[1] = 1;
        drive();
        wait_done(base + 1, 20, "t6_pre_done");
        len[0]    = 4;
        frames[0] = 1;
        drive();
        tick();
        check("t6_grant", o_grant, 4'b0001);
        tick();
        tick();
        check("t6_mid_data", m_axis_tdata, 37'(exp_beat(0, 4, 2, 1'b0)) & 37'hFFFFFFFF);
        i_reset  = 1'b1;
        i_clk_en = 1'b0;
        drive();
        tick();
        check("t6_rst_grant", o_grant, 4'b0);
        check("t6_rst_ready", s_axis_tready, 4'b0);
        check("t6_rst_mvalid", m_axis_tvalid, 1'b0);
        i_reset   = 1'b0;
        i_clk_en  = 1'b1;
        pos[0]    = 0;
        len[0]    = 2;
        frames[0] = 1;
        len[2]    = 2;
        frames[2] = 1;
        drive();
        tick();
        check("t6_first_win", o_grant, 4'b0001);
        wait_done(base + 3, 30, "t6_done");
        check("final_underrun_cnt", und_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
